// File: rtl/s4_apb_arbiter.sv
// Round-robin arbiter sharing the S4 APB slave port among NUM_REQ requesters.
// Latency: accept c0, SETUP c1, ACCESS c2 (+wait states), response pulse the cycle after ACCESS ends.
// Backpressure: one transfer in flight; req_ready only pulses in IDLE, requesters hold commands until granted.
module s4_apb_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                            ACLK,
    input  logic                            ARESETn,
    input  logic                            ASW_RESET,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ-1:0]              req_write,
    input  logic [NUM_REQ*ADDR_W-1:0]       req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]       req_wdata,
    input  logic [NUM_REQ*(DATA_W/8)-1:0]   req_strb,
    output logic [NUM_REQ-1:0]              rsp_valid,
    output logic [DATA_W-1:0]               rsp_rdata,
    output logic                            rsp_err,
    output logic                            S4_PSEL,
    output logic                            S4_PENABLE,
    output logic                            S4_PWRITE,
    output logic [ADDR_W-1:0]               S4_PADDR,
    output logic [DATA_W-1:0]               S4_PDATA,
    output logic [DATA_W/8-1:0]             S4_PSTRB,
    input  logic [DATA_W-1:0]               S4_PRDATA,
    input  logic                            S4_PREADY,
    input  logic                            S4_PSLVERR
);

    localparam int STRB_W = DATA_W / 8;
    localparam int PTR_W  = $clog2(NUM_REQ);
    localparam int CNT_W  = $clog2(TIMEOUT);
    localparam logic [PTR_W-1:0] PTR_RST  = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_ACCESS
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [PTR_W-1:0]    ptr_q;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    cand_idx;
    logic                grant_any;
    int                  cand;
    logic [CNT_W-1:0]    cnt_q;
    logic                lat_write_q;
    logic [ADDR_W-1:0]   lat_addr_q;
    logic [DATA_W-1:0]   lat_wdata_q;
    logic [STRB_W-1:0]   lat_strb_q;
    logic                accept;
    logic                tmo_hit;
    logic                done;

    // Round-robin search: first valid requester after the last winner, wrapping.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = PTR_W'(cand);
            if (!grant_any && req_valid[cand_idx]) begin
                grant_any = 1'b1;
                grant_idx = cand_idx;
            end
        end
    end

    // Soft reset blocks new grants; ACCESS completes on PREADY or on the last timeout cycle.
    assign accept  = (state_q == ST_IDLE) && grant_any && !ASW_RESET;
    assign tmo_hit = (cnt_q == CNT_LAST);
    assign done    = (state_q == ST_ACCESS) && !ASW_RESET && (S4_PREADY || tmo_hit);

    // One-hot grant; gated by the async reset so every output reads 0 while it is held.
    always_comb begin
        req_ready = '0;
        if (accept && ARESETn) begin
            req_ready[grant_idx] = 1'b1;
        end
    end

    // FSM state register.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and APB signal group; read transfers keep PDATA/PSTRB at zero.
    always_comb begin
        state_d    = state_q;
        S4_PSEL    = 1'b0;
        S4_PENABLE = 1'b0;
        S4_PWRITE  = 1'b0;
        S4_PADDR   = '0;
        S4_PDATA   = '0;
        S4_PSTRB   = '0;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                state_d = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (S4_PREADY || tmo_hit) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (ASW_RESET) begin
            state_d = ST_IDLE;
        end
        if (state_q == ST_SETUP || state_q == ST_ACCESS) begin
            S4_PSEL    = 1'b1;
            S4_PENABLE = (state_q == ST_ACCESS);
            S4_PWRITE  = lat_write_q;
            S4_PADDR   = lat_addr_q;
            if (lat_write_q) begin
                S4_PDATA = lat_wdata_q;
                S4_PSTRB = lat_strb_q;
            end
        end
    end

    // Command latch, rr pointer, timeout counter and the registered response pulse.
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            ptr_q       <= PTR_RST;
            cnt_q       <= '0;
            lat_write_q <= 1'b0;
            lat_addr_q  <= '0;
            lat_wdata_q <= '0;
            lat_strb_q  <= '0;
            rsp_valid   <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
        end else if (ASW_RESET) begin
            ptr_q     <= PTR_RST;
            cnt_q     <= '0;
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            rsp_valid <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            if (accept) begin
                ptr_q       <= grant_idx;
                lat_write_q <= req_write[grant_idx];
                lat_addr_q  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
                lat_wdata_q <= req_wdata[grant_idx*DATA_W +: DATA_W];
                lat_strb_q  <= req_strb[grant_idx*STRB_W +: STRB_W];
            end
            if (state_q == ST_SETUP) begin
                cnt_q <= '0;
            end else if (state_q == ST_ACCESS && !S4_PREADY && !tmo_hit) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            if (done) begin
                rsp_valid[ptr_q] <= 1'b1;
                rsp_rdata        <= (S4_PREADY && !lat_write_q) ? S4_PRDATA : '0;
                rsp_err          <= S4_PREADY ? S4_PSLVERR : 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_s4_apb_arbiter.sv
// Bench for s4_apb_arbiter: arbitration table, directed wait/timeout/abort/reset sequences, random traffic.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Random phase drives a wait-state slave and compares against a transaction-level model.
module tb_s4_apb_arbiter;

    localparam int N   = 4;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int SW  = 4;
    localparam int TMO = 16;

    logic            ACLK = 1'b0;
    logic            ARESETn;
    logic            ASW_RESET;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N-1:0]    req_write;
    logic [N*AW-1:0] req_addr;
    logic [N*DW-1:0] req_wdata;
    logic [N*SW-1:0] req_strb;
    logic [N-1:0]    rsp_valid;
    logic [DW-1:0]   rsp_rdata;
    logic            rsp_err;
    logic            S4_PSEL;
    logic            S4_PENABLE;
    logic            S4_PWRITE;
    logic [AW-1:0]   S4_PADDR;
    logic [DW-1:0]   S4_PDATA;
    logic [SW-1:0]   S4_PSTRB;
    logic [DW-1:0]   S4_PRDATA;
    logic            S4_PREADY;
    logic            S4_PSLVERR;

    int checks   = 0;
    int failures = 0;

    s4_apb_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .ACLK(ACLK), .ARESETn(ARESETn), .ASW_RESET(ASW_RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .S4_PSEL(S4_PSEL), .S4_PENABLE(S4_PENABLE), .S4_PWRITE(S4_PWRITE),
        .S4_PADDR(S4_PADDR), .S4_PDATA(S4_PDATA), .S4_PSTRB(S4_PSTRB),
        .S4_PRDATA(S4_PRDATA), .S4_PREADY(S4_PREADY), .S4_PSLVERR(S4_PSLVERR)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [N-1:0] valid;
        logic         wr;
        int           exp_idx;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge ACLK);
        #1;
    endtask

    task automatic smp();
        @(negedge ACLK);
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] one = 1;
        return one << i;
    endfunction

    function automatic logic [31:0] fa(input int i);
        return 32'h40 + 32'(i) * 32'h100;
    endfunction

    function automatic logic [31:0] fd(input int i);
        return 32'hA5A5_0001 + 32'(i);
    endfunction

    function automatic logic [3:0] fs(input int i);
        logic [3:0] t = 4'hF;
        return t >> i;
    endfunction

    // Fixed per-requester commands, all of the same direction.
    task automatic set_cmds(input logic wr);
        for (int i = 0; i < N; i++) begin
            req_write[i]            = wr;
            req_addr[i*AW +: AW]    = fa(i);
            req_wdata[i*DW +: DW]   = fd(i);
            req_strb[i*SW +: SW]    = fs(i);
        end
    endtask

    // One zero-wait transfer: accept c0, SETUP c1, ACCESS c2, response c3.
    task automatic run_vec(input vec_t v, input int n);
        set_cmds(v.wr);
        req_valid  = v.valid;
        S4_PREADY  = 1'b1;
        S4_PRDATA  = 32'h1234_5678;
        S4_PSLVERR = 1'b0;
        smp();
        chk($sformatf("vec%0d_ready", n), req_ready, (v.exp_idx < 0) ? '0 : oh(v.exp_idx));
        tick();
        req_valid = '0;
        if (v.exp_idx >= 0) begin
            smp();
            chk($sformatf("vec%0d_setup_psel", n), S4_PSEL, 1);
            chk($sformatf("vec%0d_setup_penable", n), S4_PENABLE, 0);
            chk($sformatf("vec%0d_paddr", n), S4_PADDR, fa(v.exp_idx));
            chk($sformatf("vec%0d_pwrite", n), S4_PWRITE, v.wr);
            chk($sformatf("vec%0d_pstrb", n), S4_PSTRB, v.wr ? fs(v.exp_idx) : 4'h0);
            chk($sformatf("vec%0d_pdata", n), S4_PDATA, v.wr ? fd(v.exp_idx) : 32'h0);
            tick();
            smp();
            chk($sformatf("vec%0d_access_penable", n), S4_PENABLE, 1);
            chk($sformatf("vec%0d_early_rsp", n), rsp_valid, 0);
            tick();
            smp();
            chk($sformatf("vec%0d_rsp_valid", n), rsp_valid, oh(v.exp_idx));
            chk($sformatf("vec%0d_rsp_err", n), rsp_err, 0);
            chk($sformatf("vec%0d_rsp_rdata", n), rsp_rdata, v.wr ? 32'h0 : 32'h1234_5678);
            chk($sformatf("vec%0d_idle_psel", n), S4_PSEL, 0);
            tick();
        end
    endtask

    vec_t vt[12];

    // Random-phase model state
    logic [N-1:0]  pend;
    logic          cw [N];
    logic [31:0]   ca [N];
    logic [31:0]   cd [N];
    logic [3:0]    cs [N];

    initial begin
        int acc;
        bit got;
        int last, busy, k, end_k, waits, cur, win;
        bit tmo_tx, in_xfer, rsp_cyc, idle;
        logic cur_w;
        logic [31:0] cur_a, cur_d, exp_rd;
        logic [3:0] cur_s;
        logic exp_er;

        vt[0]  = '{4'b0001, 1'b1, 0};
        vt[1]  = '{4'b1111, 1'b0, 1};
        vt[2]  = '{4'b1111, 1'b1, 2};
        vt[3]  = '{4'b1111, 1'b0, 3};
        vt[4]  = '{4'b1111, 1'b1, 0};
        vt[5]  = '{4'b1001, 1'b0, 3};
        vt[6]  = '{4'b0110, 1'b1, 1};
        vt[7]  = '{4'b0011, 1'b0, 0};
        vt[8]  = '{4'b0001, 1'b1, 0};
        vt[9]  = '{4'b0100, 1'b0, 2};
        vt[10] = '{4'b1100, 1'b1, 3};
        vt[11] = '{4'b0000, 1'b0, -1};

        ARESETn    = 1'b0;
        ASW_RESET  = 1'b0;
        req_valid  = '0;
        set_cmds(1'b0);
        S4_PRDATA  = '0;
        S4_PREADY  = 1'b0;
        S4_PSLVERR = 1'b0;
        #3;
        chk("rst_psel", S4_PSEL, 0);
        chk("rst_penable", S4_PENABLE, 0);
        chk("rst_paddr", S4_PADDR, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_req_ready", req_ready, 0);
        tick();
        tick();
        ARESETn = 1'b1;

        for (int i = 0; i < 12; i++) begin
            run_vec(vt[i], i);
        end

        // Read with five wait states, then PREADY with error (pointer now 3)
        set_cmds(1'b0);
        req_valid = 4'b0010;
        S4_PREADY = 1'b0;
        smp();
        chk("t3_ready", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        smp();
        chk("t3_setup_psel", S4_PSEL, 1);
        tick();
        for (int w = 0; w < 5; w++) begin
            smp();
            chk("t3_wait_penable", S4_PENABLE, 1);
            chk("t3_wait_paddr", S4_PADDR, fa(1));
            chk("t3_wait_pwrite", S4_PWRITE, 0);
            chk("t3_wait_pstrb", S4_PSTRB, 0);
            chk("t3_wait_pdata", S4_PDATA, 0);
            chk("t3_wait_rsp", rsp_valid, 0);
            tick();
        end
        S4_PREADY  = 1'b1;
        S4_PRDATA  = 32'hDEAD_BEEF;
        S4_PSLVERR = 1'b1;
        smp();
        chk("t3_last_penable", S4_PENABLE, 1);
        tick();
        S4_PREADY  = 1'b0;
        S4_PRDATA  = '0;
        S4_PSLVERR = 1'b0;
        smp();
        chk("t3_rsp_valid", rsp_valid, 4'b0010);
        chk("t3_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk("t3_rsp_err", rsp_err, 1);
        tick();

        // Timeout: PREADY never rises (pointer now 1)
        set_cmds(1'b1);
        req_valid = 4'b0100;
        smp();
        chk("t4_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        acc = 0;
        got = 0;
        for (int n = 0; n < 40 && !got; n++) begin
            smp();
            if (S4_PENABLE) acc++;
            if (rsp_valid != 0) got = 1;
            else tick();
        end
        chk("t4_access_cycles", acc, TMO);
        chk("t4_rsp_valid", rsp_valid, 4'b0100);
        chk("t4_rsp_err", rsp_err, 1);
        chk("t4_rsp_rdata", rsp_rdata, 0);
        chk("t4_psel_after", S4_PSEL, 0);
        tick();
        run_vec('{4'b1000, 1'b0, 3}, 100);

        // Soft reset during ACCESS with PREADY high: abort, no response, pointer back to N-1
        set_cmds(1'b0);
        req_valid = 4'b0100;
        S4_PREADY = 1'b0;
        smp();
        chk("t5_ready", req_ready, 4'b0100);
        tick();
        req_valid = '0;
        smp();
        tick();
        smp();
        chk("t5_access", S4_PENABLE, 1);
        ASW_RESET = 1'b1;
        S4_PREADY = 1'b1;
        req_valid = 4'b1111;
        #1;
        chk("t5_ready_blocked", req_ready, 0);
        tick();
        ASW_RESET = 1'b0;
        smp();
        chk("t5_psel", S4_PSEL, 0);
        chk("t5_penable", S4_PENABLE, 0);
        chk("t5_no_rsp", rsp_valid, 0);
        chk("t5_grant0", req_ready, 4'b0001);
        tick();
        req_valid = '0;
        smp();
        chk("t5_setup_paddr", S4_PADDR, fa(0));
        chk("t5_no_rsp2", rsp_valid, 0);
        tick();
        smp();
        tick();
        smp();
        chk("t5_rsp_valid", rsp_valid, 4'b0001);

        tick();
        // Async reset in the middle of SETUP (pointer now 0)
        set_cmds(1'b1);
        req_valid = 4'b0010;
        smp();
        chk("t6_ready", req_ready, 4'b0010);
        tick();
        req_valid = 4'b1111;
        smp();
        chk("t6_setup_psel", S4_PSEL, 1);
        #2;
        ARESETn = 1'b0;
        #1;
        chk("t6_psel", S4_PSEL, 0);
        chk("t6_penable", S4_PENABLE, 0);
        chk("t6_pwrite", S4_PWRITE, 0);
        chk("t6_paddr", S4_PADDR, 0);
        chk("t6_pdata", S4_PDATA, 0);
        chk("t6_pstrb", S4_PSTRB, 0);
        chk("t6_req_ready", req_ready, 0);
        chk("t6_rsp_valid", rsp_valid, 0);
        tick();
        tick();
        ARESETn = 1'b1;
        smp();
        chk("t6_grant_after_reset", req_ready, 4'b0001);
        req_valid = '0;
        tick();
        tick();

        // Random traffic against a transaction-level model
        pend = '0;
        for (int i = 0; i < N; i++) begin
            cw[i] = 0; ca[i] = 0; cd[i] = 0; cs[i] = 0;
        end
        last = N - 1; busy = 0; k = 0; end_k = 0; cur = 0; waits = 0; tmo_tx = 0;
        cur_w = 0; cur_a = 0; cur_d = 0; cur_s = 0; exp_rd = 0; exp_er = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            if (busy != 0) k++;
            for (int i = 0; i < N; i++) begin
                if (!pend[i] && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    cw[i] = 1'($urandom);
                    ca[i] = $urandom;
                    cd[i] = $urandom;
                    cs[i] = 4'($urandom);
                end
                req_write[i]          = cw[i];
                req_addr[i*AW +: AW]  = ca[i];
                req_wdata[i*DW +: DW] = cd[i];
                req_strb[i*SW +: SW]  = cs[i];
            end
            req_valid = pend;
            in_xfer = (busy != 0) && k >= 1 && k <= end_k;
            rsp_cyc = (busy != 0) && k == end_k + 1;
            idle    = (busy == 0) || rsp_cyc;
            if ((busy != 0) && k >= 2 && k <= end_k) S4_PREADY = (k - 2 == waits);
            else S4_PREADY = 1'($urandom);
            S4_PRDATA  = $urandom;
            S4_PSLVERR = 1'($urandom);
            if ((busy != 0) && k == end_k) begin
                exp_rd = tmo_tx ? 32'h0 : (cur_w ? 32'h0 : S4_PRDATA);
                exp_er = tmo_tx ? 1'b1 : S4_PSLVERR;
            end
            win = -1;
            if (idle) begin
                for (int j = 1; j <= N; j++) begin
                    if (win < 0 && pend[(last + j) % N]) win = (last + j) % N;
                end
            end
            smp();
            chk("rnd_rsp_valid", rsp_valid, rsp_cyc ? oh(cur) : '0);
            chk("rnd_rsp_rdata", rsp_rdata, rsp_cyc ? exp_rd : 32'h0);
            chk("rnd_rsp_err", rsp_err, rsp_cyc ? exp_er : 1'b0);
            chk("rnd_psel", S4_PSEL, in_xfer);
            chk("rnd_penable", S4_PENABLE, in_xfer && k >= 2);
            chk("rnd_paddr", S4_PADDR, in_xfer ? cur_a : 32'h0);
            chk("rnd_pwrite", S4_PWRITE, in_xfer && cur_w);
            chk("rnd_pdata", S4_PDATA, (in_xfer && cur_w) ? cur_d : 32'h0);
            chk("rnd_pstrb", S4_PSTRB, (in_xfer && cur_w) ? cur_s : 4'h0);
            chk("rnd_req_ready", req_ready, (win >= 0) ? oh(win) : '0);
            if (rsp_cyc) busy = 0;
            if (win >= 0) begin
                busy  = 1;
                k     = 0;
                cur   = win;
                last  = win;
                cur_w = cw[win];
                cur_a = ca[win];
                cur_d = cd[win];
                cur_s = cs[win];
                pend[win] = 1'b0;
                waits  = ($urandom_range(0, 7) == 0) ? TMO + 3 : int'($urandom_range(0, 3));
                tmo_tx = (waits >= TMO);
                end_k  = tmo_tx ? TMO + 1 : 2 + waits;
            end
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
